pipelined_adder: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor that splits the operands into CHUNK-bit slices with one register stage per slice. It replaces the 4-bit ripple-carry adder in the datapath that feeds the 7-segment display path. Input and output use valid/ready handshakes. Sustains one operation per cycle with a fixed latency and reports carry and signed overflow.

---
 rtl/pipelined_adder.sv | 112 +++++++++++
 tb/tb_pipelined_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per register stage, valid/ready on both sides.
// Optional signed saturation of the result when the macro ADDER_SAT_EN is defined.
module pipelined_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   if (WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   // x: finished sum slices below the current stage, untouched A slices above it.
   // y: the effective B operand (already inverted for subtraction).
   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             c;
      logic             ovf;
   } stage_t;

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];
   logic   stall;

   always_comb begin
      stage_t           src;
      logic [CHUNK:0]   part;
      logic             sum_ovf;

      // NOTE: every combinational output gets a default before any branch; this is what keeps the block latch-free.
      stall    = stage_q[STAGES-1].vld && !out_ready;
      in_ready = !stall;
      src      = '0;
      part     = '0;
      sum_ovf  = 1'b0;

      for (int k = 0; k < STAGES; k++) begin
         stage_d[k] = stage_q[k];

         if (k == 0) begin
            src.vld = in_valid;
            src.x   = a;
            src.y   = sub ? ~b : b;
            src.c   = sub ? ~cin : cin;
            src.ovf = 1'b0;
         end else begin
            src = stage_q[(k > 0) ? k - 1 : 0];
         end

         part = {1'b0, src.x[k*CHUNK +: CHUNK]} + {1'b0, src.y[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, src.c};
         sum_ovf = (src.x[WIDTH-1] == src.y[WIDTH-1]) && (part[CHUNK-1] != src.x[WIDTH-1]);

         // Bubbles move the valid bit only, so the output data holds its last value while idle.
         if (!stall) begin
            stage_d[k].vld = src.vld;
            if (src.vld) begin
               stage_d[k].x                  = src.x;
               stage_d[k].x[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
               stage_d[k].y                  = src.y;
               stage_d[k].c                  = part[CHUNK];
               stage_d[k].ovf                = 1'b0;
               if (k == STAGES - 1) begin
                  stage_d[k].ovf = sum_ovf;
`ifdef ADDER_SAT_EN
                  if (sum_ovf) begin
                     stage_d[k].x = {src.x[WIDTH-1], {(WIDTH-1){~src.x[WIDTH-1]}}};
                  end
`endif
               end
            end
         end
      end
   end

   // NOTE: the data fields are reset along with the valid bits because sum/cout/ovf must read zero during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value.
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign out_valid = stage_q[STAGES-1].vld;
   assign sum       = stage_q[STAGES-1].x;
   assign cout      = stage_q[STAGES-1].c;
   assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases on an 8/4 instance plus a randomized
// scoreboard run on 8/4, 16/4 and 8/8 instances. Honours ADDER_SAT_EN in its expectations.
module tb_pipelined_adder;

   typedef struct {
      logic [17:0] res;   // {ovf, cout, sum[15:0]}
      int          t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_d = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
   function automatic logic [17:0] ref_model(input int w, input longint a, input longint b,
                                             input bit cin, input bit sub);
      longint half, full, sa, sb, u, s;
      logic [15:0] r_sum;
      bit r_cout, r_ovf;
      half = longint'(1) << (w - 1);
      full = half * 2;
      sa   = (a >= half) ? a - full : a;
      sb   = (b >= half) ? b - full : b;
      if (sub) begin
         u = a - b - longint'(cin);
         s = sa - sb - longint'(cin);
         r_cout = (u >= 0);
      end else begin
         u = a + b + longint'(cin);
         s = sa + sb + longint'(cin);
         r_cout = (u >= full);
      end
      r_sum = 16'(u & (full - 1));
      r_ovf = (s >= half) || (s < -half);
`ifdef ADDER_SAT_EN
      if (r_ovf) r_sum = (sa < 0) ? 16'(half) : 16'(half - 1);
`endif
      return {r_ovf, r_cout, r_sum};
   endfunction

   // ---------------- directed instance (WIDTH=8, CHUNK=4) ----------------
   logic       d_in_valid = 1'b0, d_in_ready, d_cin = 1'b0, d_sub = 1'b0;
   logic       d_out_valid, d_out_ready = 1'b0, d_cout, d_ovf;
   logic [7:0] d_a = '0, d_b = '0, d_sum;

   pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst_d), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
      .out_valid(d_out_valid), .out_ready(d_out_ready),
      .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
   );

`ifdef ADDER_SAT_EN
   localparam logic [7:0] OVF_SUM = 8'h7F;
   localparam logic [7:0] RST_SUM_A = 8'h80;
`else
   localparam logic [7:0] OVF_SUM = 8'h80;
   localparam logic [7:0] RST_SUM_A = 8'h20;
`endif

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
      @(negedge clk);
      d_a = a; d_b = b; d_cin = cin; d_sub = sub;
      d_in_valid = 1'b1; d_out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, 32'(d_in_ready), 1);
      @(negedge clk);
      d_in_valid = 1'b0;
      check({tag, "_early"}, 32'(d_out_valid), 0);
      @(negedge clk);
      check({tag, "_valid"}, 32'(d_out_valid), 1);
      check({tag, "_sum"}, 32'(d_sum), 32'(e_sum));
      check({tag, "_cout"}, 32'(d_cout), 32'(e_cout));
      check({tag, "_ovf"}, 32'(d_ovf), 32'(e_ovf));
      @(negedge clk);
      check({tag, "_drained"}, 32'(d_out_valid), 0);
   endtask

   // ---------------- randomized sweep instances ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int W  = (g == 1) ? 16 : 8;
      localparam int C  = (g == 2) ? 8 : 4;
      localparam int ST = W / C;

      logic         s_in_valid, s_in_ready, s_cin, s_sub;
      logic         s_out_valid, s_out_ready, s_cout, s_ovf;
      logic [W-1:0] s_a, s_b, s_sum;
      exp_t         q[$];
      int           adv;
      int           accepted;

      pipelined_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
         .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
         .out_valid(s_out_valid), .out_ready(s_out_ready),
         .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
      );

      initial begin
         logic        exp_valid, exp_ready;
         logic [17:0] r;
         string       pfx;
         pfx = $sformatf("W%0dC%0d", W, C);
         s_in_valid = 1'b0; s_out_ready = 1'b0; s_cin = 1'b0; s_sub = 1'b0;
         s_a = '0; s_b = '0;
         adv = 0; accepted = 0;
         wait (rst == 1'b0);
         for (int it = 0; it < 20000 && !(accepted >= 1000 && q.size() == 0); it++) begin
            @(negedge clk);
            s_in_valid  = (accepted < 1000) && ($urandom_range(0, 9) != 0);
            s_a         = W'($urandom());
            s_b         = W'($urandom());
            s_cin       = 1'($urandom());
            s_sub       = 1'($urandom());
            s_out_ready = (accepted >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            // The head transaction shows at the output once it has moved through ST advancing edges.
            exp_valid = (q.size() > 0) && (adv - q[0].t0 == ST);
            exp_ready = !(exp_valid && !s_out_ready);
            check({pfx, "_out_valid"}, 32'(s_out_valid), 32'(exp_valid));
            check({pfx, "_in_ready"}, 32'(s_in_ready), 32'(exp_ready));
            if (exp_valid && s_out_valid) begin
               r = q[0].res;
               check({pfx, "_sum"}, 32'(s_sum), 32'(r[W-1:0]));
               check({pfx, "_cout"}, 32'(s_cout), 32'(r[16]));
               check({pfx, "_ovf"}, 32'(s_ovf), 32'(r[17]));
            end
            if (exp_valid && s_out_ready) void'(q.pop_front());
            if (s_in_valid && exp_ready) begin
               q.push_back('{res: ref_model(W, longint'(s_a), longint'(s_b), s_cin, s_sub), t0: adv});
               accepted++;
            end
            if (exp_ready) adv++;
         end
         s_in_valid = 1'b0;
         check({pfx, "_accepted"}, 32'(accepted), 1000);
         check({pfx, "_drained"}, 32'(q.size()), 0);
         done_cnt++;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] got[$];
      int op_i;
      int stall_left;

      #1;
      check("rst_out_valid", 32'(d_out_valid), 0);
      check("rst_sum", 32'(d_sum), 0);
      check("rst_cout", 32'(d_cout), 0);
      check("rst_ovf", 32'(d_ovf), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0; rst_d = 1'b0;
      #1 check("post_rst_in_ready", 32'(d_in_ready), 1);

      run_op("add_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, OVF_SUM, 1'b0, 1'b1);
      run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("sub_bin",   8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
      run_op("sub_neg",   8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);

      // Back-pressure: four ops, out_ready held low for three cycles once the first result shows.
      op_i = 0;
      stall_left = -1;
      for (int it = 0; it < 30 && got.size() < 4; it++) begin
         @(negedge clk);
         if (d_out_valid && stall_left < 0) stall_left = 3;
         d_out_ready = !(stall_left > 0);
         d_in_valid  = (op_i < 4);
         d_a = 8'(op_i + 1); d_b = 8'(op_i + 1); d_cin = 1'b0; d_sub = 1'b0;
         #1;
         if (stall_left > 0) begin
            check("bp_in_ready", 32'(d_in_ready), 0);
            check("bp_valid", 32'(d_out_valid), 1);
            check("bp_hold", 32'(d_sum), 32'h02);
         end
         if (d_out_valid && d_out_ready) got.push_back(d_sum);
         if (d_in_valid && d_in_ready) op_i++;
         if (stall_left > 0) stall_left--;
      end
      d_in_valid = 1'b0; d_out_ready = 1'b1;
      check("bp_count", 32'(got.size()), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         check($sformatf("bp_res%0d", i), 32'(got[i]), 32'(2 * (i + 1)));
      end
      @(negedge clk);
      check("bp_no_dup", 32'(d_out_valid), 0);

      // Reset with one result at the output and a second op still in flight.
      @(negedge clk);
      d_a = 8'h90; d_b = 8'h90; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
      @(negedge clk);
      d_a = 8'h0F; d_b = 8'h01;
      @(negedge clk);
      d_in_valid = 1'b0;
      check("pre_rst_valid", 32'(d_out_valid), 1);
      check("pre_rst_sum", 32'(d_sum), 32'(RST_SUM_A));
      check("pre_rst_cout", 32'(d_cout), 1);
      check("pre_rst_ovf", 32'(d_ovf), 1);
      rst_d = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(d_out_valid), 0);
      check("mid_rst_sum", 32'(d_sum), 0);
      check("mid_rst_cout", 32'(d_cout), 0);
      check("mid_rst_ovf", 32'(d_ovf), 0);
      @(negedge clk);
      rst_d = 1'b0;
      #1 check("rel_in_ready", 32'(d_in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rel_no_result", 32'(d_out_valid), 0);
      end

      for (int i = 0; i < 60000 && done_cnt < 3; i++) @(posedge clk);
      check("sweeps_done", 32'(done_cnt), 3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
